// File: rtl/sram_fb_writer.sv
// rtl/sram_fb_writer.sv - pixel-beat to async SRAM write engine with front/back double buffering.
// Optional post-swap clear pass of the new back buffer is enabled by defining SRAM_FB_CLEAR_EN.
module sram_fb_writer #(
    parameter int          WE_CYCLES   = 2,
    parameter logic [7:0]  BG_COLOR    = 8'h00,
    parameter int          CLEAR_WORDS = 524288
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [19:0] fb_addr_i,
    input  logic        hit_i,
    input  logic [7:0]  bri_i,
    input  logic        swap_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [19:0] sram_addr_o,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic        sram_ub_n_o,
    output logic        sram_lb_n_o,
    output logic        swap_req_o,
    input  logic        swap_ack_i,
    output logic        front_buf_o
);

    if (WE_CYCLES < 1 || WE_CYCLES > 15) begin : g_bad_we_cycles
        $error("sram_fb_writer: WE_CYCLES must be 1..15");
    end
    if (CLEAR_WORDS < 1 || CLEAR_WORDS > 524288) begin : g_bad_clear_words
        $error("sram_fb_writer: CLEAR_WORDS must be 1..524288");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        SWAP
`ifdef SRAM_FB_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic [19:0] r_addr;
    logic [15:0] r_dq;
    logic        r_dq_oe;
    logic        r_ce_n;
    logic        r_we_n;
    logic        r_ub_n;
    logic        r_lb_n;
    logic        r_swap_req;
    logic        r_front;
    logic        r_back;
    logic        r_swap;
    logic [3:0]  r_we_cnt;
`ifdef SRAM_FB_CLEAR_EN
    logic [18:0] r_clr_cnt;
    logic        r_clr_active;
`endif

    logic [7:0]  w_pixel;

    assign w_pixel = hit_i ? bri_i : BG_COLOR;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_ready      <= 1'b0;
            r_addr       <= 20'h0;
            r_dq         <= 16'h0;
            r_dq_oe      <= 1'b0;
            r_ce_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_ub_n       <= 1'b1;
            r_lb_n       <= 1'b1;
            r_swap_req   <= 1'b0;
            r_front      <= 1'b0;
            r_back       <= 1'b1;
            r_swap       <= 1'b0;
            r_we_cnt     <= 4'h0;
`ifdef SRAM_FB_CLEAR_EN
            r_clr_cnt    <= 19'h0;
            r_clr_active <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // r_ready is low for the first IDLE cycle after reset release
                    if (valid_i && r_ready) begin
                        r_addr  <= {r_back, fb_addr_i[19:1]};
                        r_dq    <= {w_pixel, w_pixel};
                        r_lb_n  <= fb_addr_i[0];
                        r_ub_n  <= ~fb_addr_i[0];
                        r_ce_n  <= 1'b0;
                        r_dq_oe <= 1'b1;
                        r_swap  <= swap_i;
                        r_ready <= 1'b0;
                        r_state <= SETUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_we_n   <= 1'b0;
                    r_we_cnt <= 4'(WE_CYCLES - 1);
                    r_state  <= WRITE;
                end
                WRITE: begin
                    if (r_we_cnt == 4'h0) begin
                        r_we_n  <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_we_cnt <= r_we_cnt - 4'h1;
                    end
                end
                HOLD: begin
                    r_ce_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
`ifdef SRAM_FB_CLEAR_EN
                    if (r_clr_active) begin
                        if (r_clr_cnt == 19'(CLEAR_WORDS - 1)) begin
                            r_clr_cnt    <= 19'h0;
                            r_clr_active <= 1'b0;
                            r_ready      <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 19'h1;
                            r_state   <= CLEAR;
                        end
                    end else
`endif
                    if (r_swap) begin
                        r_swap_req <= 1'b1;
                        r_state    <= SWAP;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                SWAP: begin
                    if (swap_ack_i) begin
                        r_front    <= r_back;
                        r_back     <= ~r_back;
                        r_swap_req <= 1'b0;
                        r_swap     <= 1'b0;
`ifdef SRAM_FB_CLEAR_EN
                        r_clr_active <= 1'b1;
                        r_state      <= CLEAR;
`else
                        r_ready <= 1'b1;
                        r_state <= IDLE;
`endif
                    end
                end
`ifdef SRAM_FB_CLEAR_EN
                CLEAR: begin
                    // r_back has already flipped, so this targets the new back buffer
                    r_addr  <= {r_back, r_clr_cnt};
                    r_dq    <= {BG_COLOR, BG_COLOR};
                    r_ub_n  <= 1'b0;
                    r_lb_n  <= 1'b0;
                    r_ce_n  <= 1'b0;
                    r_dq_oe <= 1'b1;
                    r_state <= SETUP;
                end
`endif
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_o      = r_ready;
    assign sram_addr_o  = r_addr;
    assign sram_dq_o    = r_dq;
    assign sram_dq_oe_o = r_dq_oe;
    assign sram_ce_n_o  = r_ce_n;
    assign sram_oe_n_o  = 1'b1;
    assign sram_we_n_o  = r_we_n;
    assign sram_ub_n_o  = r_ub_n;
    assign sram_lb_n_o  = r_lb_n;
    assign swap_req_o   = r_swap_req;
    assign front_buf_o  = r_front;

endmodule

// File: tb/tb_sram_fb_writer.sv
// tb/tb_sram_fb_writer.sv - directed self-checking bench for sram_fb_writer.
module tb_sram_fb_writer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [19:0] fb_addr_i;
    logic        hit_i;
    logic [7:0]  bri_i;
    logic        swap_i;
    logic        valid_i;
    logic        ready_o;
    logic [19:0] sram_addr_o;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic        sram_ub_n_o;
    logic        sram_lb_n_o;
    logic        swap_req_o;
    logic        swap_ack_i;
    logic        front_buf_o;

    int errors = 0;
    int checks = 0;

    sram_fb_writer #(
        .WE_CYCLES   (2),
        .BG_COLOR    (8'h11),
        .CLEAR_WORDS (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fb_addr_i    (fb_addr_i),
        .hit_i        (hit_i),
        .bri_i        (bri_i),
        .swap_i       (swap_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .sram_addr_o  (sram_addr_o),
        .sram_dq_o    (sram_dq_o),
        .sram_dq_oe_o (sram_dq_oe_o),
        .sram_ce_n_o  (sram_ce_n_o),
        .sram_oe_n_o  (sram_oe_n_o),
        .sram_we_n_o  (sram_we_n_o),
        .sram_ub_n_o  (sram_ub_n_o),
        .sram_lb_n_o  (sram_lb_n_o),
        .swap_req_o   (swap_req_o),
        .swap_ack_i   (swap_ack_i),
        .front_buf_o  (front_buf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one beat, accepts it, and checks every cycle of SETUP/WRITE/HOLD and the cycle after.
    task automatic write_pixel(input logic [19:0] addr, input logic hit, input logic [7:0] bri,
                               input logic swp, input logic [19:0] exp_addr,
                               input logic [15:0] exp_dq, input logic exp_ub, input logic exp_lb);
        fb_addr_i = addr;
        hit_i     = hit;
        bri_i     = bri;
        swap_i    = swp;
        valid_i   = 1'b1;
        check("pre_ready", ready_o, 1);
        tick();
        valid_i = 1'b0;
        check("setup_addr", sram_addr_o, exp_addr);
        check("setup_dq", sram_dq_o, exp_dq);
        check("setup_ub", sram_ub_n_o, exp_ub);
        check("setup_lb", sram_lb_n_o, exp_lb);
        check("setup_ce", sram_ce_n_o, 0);
        check("setup_oe_dq", sram_dq_oe_o, 1);
        check("setup_we", sram_we_n_o, 1);
        check("setup_ready", ready_o, 0);
        tick();
        check("write1_we", sram_we_n_o, 0);
        tick();
        check("write2_we", sram_we_n_o, 0);
        check("write2_addr", sram_addr_o, exp_addr);
        tick();
        check("hold_we", sram_we_n_o, 1);
        check("hold_ce", sram_ce_n_o, 0);
        check("hold_dq_oe", sram_dq_oe_o, 1);
        check("hold_dq", sram_dq_o, exp_dq);
        tick();
        check("post_ce", sram_ce_n_o, 1);
        check("post_dq_oe", sram_dq_oe_o, 0);
        check("post_ub", sram_ub_n_o, 1);
        check("post_lb", sram_lb_n_o, 1);
        check("post_ready", ready_o, !swp);
        check("post_swap_req", swap_req_o, swp);
    endtask

    initial begin
        rst_ni     = 1'b0;
        fb_addr_i  = 20'h0;
        hit_i      = 1'b0;
        bri_i      = 8'h0;
        swap_i     = 1'b0;
        valid_i    = 1'b0;
        swap_ack_i = 1'b0;

        tick(); tick(); tick();
        check("rst_ready", ready_o, 0);
        check("rst_ce", sram_ce_n_o, 1);
        check("rst_we", sram_we_n_o, 1);
        check("rst_oe", sram_oe_n_o, 1);
        check("rst_ub", sram_ub_n_o, 1);
        check("rst_lb", sram_lb_n_o, 1);
        check("rst_dq_oe", sram_dq_oe_o, 0);
        check("rst_addr", sram_addr_o, 0);
        check("rst_dq", sram_dq_o, 0);
        check("rst_swap_req", swap_req_o, 0);
        check("rst_front", front_buf_o, 0);

        rst_ni = 1'b1;
        tick();
        check("idle_ready", ready_o, 1);
        tick();
        check("idle_ce", sram_ce_n_o, 1);

        write_pixel(20'h00005, 1'b1, 8'hA5, 1'b0, 20'h80002, 16'hA5A5, 1'b0, 1'b1);
        write_pixel(20'h00004, 1'b0, 8'h77, 1'b0, 20'h80002, 16'h1111, 1'b1, 1'b0);
        write_pixel(20'h00010, 1'b1, 8'h3C, 1'b1, 20'h80008, 16'h3C3C, 1'b1, 1'b0);

        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("swap_wait_ready", ready_o, 0);
            check("swap_wait_req", swap_req_o, 1);
            check("swap_wait_ce", sram_ce_n_o, 1);
        end
        valid_i    = 1'b0;
        swap_ack_i = 1'b1;
        tick();
        swap_ack_i = 1'b0;
        check("ack_front", front_buf_o, 1);
        check("ack_swap_req", swap_req_o, 0);
`ifdef SRAM_FB_CLEAR_EN
        check("clr_enter_ready", ready_o, 0);
        for (int w = 0; w < 4; w++) begin
            tick();
            check("clr_addr", sram_addr_o, w);
            check("clr_dq", sram_dq_o, 16'h1111);
            check("clr_ub", sram_ub_n_o, 0);
            check("clr_lb", sram_lb_n_o, 0);
            check("clr_ce", sram_ce_n_o, 0);
            check("clr_ready", ready_o, 0);
            tick();
            check("clr_we1", sram_we_n_o, 0);
            tick();
            check("clr_we2", sram_we_n_o, 0);
            tick();
            check("clr_hold_we", sram_we_n_o, 1);
            check("clr_hold_ready", ready_o, 0);
            tick();
            check("clr_post_ce", sram_ce_n_o, 1);
            check("clr_post_ready", ready_o, (w == 3) ? 1 : 0);
        end
`else
        check("ack_ready", ready_o, 1);
`endif

        write_pixel(20'h00007, 1'b1, 8'h5A, 1'b0, 20'h00003, 16'h5A5A, 1'b0, 1'b1);

        swap_ack_i = 1'b1;
        tick();
        swap_ack_i = 1'b0;
        check("stray_ack_front", front_buf_o, 1);
        check("stray_ack_ready", ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_novalid_ce", sram_ce_n_o, 1);
            check("idle_novalid_we", sram_we_n_o, 1);
        end

        fb_addr_i = 20'h00021;
        hit_i     = 1'b1;
        bri_i     = 8'hC3;
        swap_i    = 1'b0;
        valid_i   = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        check("midrst_we_low", sram_we_n_o, 0);
        rst_ni = 1'b0;
        tick();
        check("midrst_we", sram_we_n_o, 1);
        check("midrst_ce", sram_ce_n_o, 1);
        check("midrst_dq_oe", sram_dq_oe_o, 0);
        check("midrst_ready", ready_o, 0);
        check("midrst_front", front_buf_o, 0);
        rst_ni = 1'b1;
        tick();
        check("midrst_after_ready", ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_quiet_we", sram_we_n_o, 1);
            check("midrst_quiet_ce", sram_ce_n_o, 1);
        end

        write_pixel(20'h00003, 1'b1, 8'h42, 1'b0, 20'h80001, 16'h4242, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_fb_writer.md
Name: sram_fb_writer

Overview:
- Drains the SRAM-clock side of the pixel crossing FIFO and turns each pixel beat into an asynchronous write cycle on the external 1Mx16 SRAM.
- Packs two 8-bit pixels per SRAM word and manages front/back double buffering.
- Holds the stream off during a buffer swap until the display scanner acknowledges it at vblank.

Parameters:
- WE_CYCLES, 2, number of clk_i cycles sram_we_n_o is held low per write (1..15).
- BG_COLOR, 8'h00, value written for pixels with hit_i=0 and by the clear pass.
- CLEAR_WORDS, 524288, number of words in one buffer cleared by the optional clear pass; must be 1..524288.

Ports:
- clk_i  in  1  SRAM-domain clock; the only clock.
- rst_ni  in  1  reset, synchronous, active-low.
- fb_addr_i  in  20  pixel address; [19:1] is the word within a buffer, [0] is the byte lane (0=low byte, 1=high byte).
- hit_i  in  1  1: write bri_i; 0: write BG_COLOR.
- bri_i  in  8  pixel brightness.
- swap_i  in  1  marks the last pixel of a frame.
- valid_i  in  1  beat present (FIFO not empty, show-ahead).
- ready_o  out  1  consume beat; drives FIFO rdreq.
- sram_addr_o  out  20  {back_buf, word address}.
- sram_dq_o  out  16  write data.
- sram_dq_oe_o  out  1  tristate enable for DQ.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o  out  1 each  SRAM strobes, active-low.
- swap_req_o  out  1  frame complete, request display swap.
- swap_ack_i  in  1  display accepted the swap (vblank).
- front_buf_o  out  1  buffer the display must scan.

Behaviour:
- States: IDLE, SETUP, WRITE, HOLD, SWAP, CLEAR (CLEAR exists only with the feature macro).
- Reset (rst_ni=0 at a clk_i edge) sets: state=IDLE; ce_n=oe_n=we_n=ub_n=lb_n=1; dq_oe=0; sram_addr_o=0; sram_dq_o=0; swap_req_o=0; front_buf_o=0; internal back_buf=1; ready_o=0 while rst_ni=0.
- Reset mid-write: we_n returns to 1 on the same edge and the beat is dropped.
- ready_o is 1 in IDLE only. It is a function of state alone, independent of valid_i.
- A beat is accepted on a cycle where valid_i=1 and ready_o=1.
- On accept:
  - Latch the beat. sram_addr_o={back_buf, fb_addr_i[19:1]}.
  - Pixel = hit_i ? bri_i : BG_COLOR. sram_dq_o={pixel, pixel}.
  - lb_n=fb_addr_i[0], ub_n=~fb_addr_i[0].
  - ce_n=0, dq_oe=1, then go to SETUP.
- SETUP: 1 cycle with we_n=1, address and data stable.
- WRITE: we_n=0 for exactly WE_CYCLES cycles.
- HOLD: 1 cycle with we_n=1; address, data and dq_oe unchanged.
- Leaving HOLD: ce_n=1, dq_oe=0, ub_n=lb_n=1. Next state is SWAP if the latched swap_i=1, else IDLE.
- Throughput: one beat per WE_CYCLES+3 cycles. Accept-to-we_n-low latency is 2 cycles.
- sram_oe_n_o is held at 1 permanently; this block never reads.
- SWAP:
  - swap_req_o=1 and ready_o=0.
  - On swap_ack_i=1: front_buf_o<=back_buf, back_buf<=~back_buf, swap_req_o<=0. Next state is CLEAR if the macro is defined, else IDLE.
- swap_ack_i outside SWAP is ignored.
- A swap beat with hit_i=0 still writes BG_COLOR before swapping.
- valid_i=0 in IDLE: strobes stay idle and nothing is written.

Optional Feature:
- Macro SRAM_FB_CLEAR_EN.
- Defined:
  - After swap ack, enter CLEAR and write BG_COLOR to both bytes (ub_n=lb_n=0) of words 0..CLEAR_WORDS-1 of the new back buffer.
  - Each word uses the same SETUP/WRITE/HOLD timing as a pixel write.
  - ready_o=0 throughout; return to IDLE after the last word.
  - A word counter of 19 bits wraps to 0 on exit.
- Undefined: there is no CLEAR state, no counter logic, and the swap goes straight to IDLE.

Test Plan:
- Reset, then idle: ce_n=we_n=oe_n=1, dq_oe=0, front_buf_o=0, ready_o=1 one cycle after rst_ni rises.
- Accept fb_addr=20'h00005, hit=1, bri=8'hA5, WE_CYCLES=2 -> sram_addr_o=20'h80002, dq=16'hA5A5, ub_n=0, lb_n=1, we_n low exactly cycles +2 and +3 after accept, ready_o=1 again at +5.
- Accept addr 20'h00004 with hit=0 and BG_COLOR=8'h11 -> dq=16'h1111, lb_n=0, ub_n=1, write lands at 20'h80002.
- Pixel with swap_i=1 -> after HOLD, swap_req_o=1 and ready_o=0 while valid_i=1 for 10 cycles. Then swap_ack_i pulse -> front_buf_o=1, and the next pixel writes with addr[19]=0.
- Drop rst_ni while we_n=0 -> we_n=1 and ce_n=1 on the next edge, state IDLE, no further strobe activity.
- With SRAM_FB_CLEAR_EN and CLEAR_WORDS=4:
  - After swap ack, exactly 4 writes of BG_COLOR to words {back,0..3} with ub_n=lb_n=0.
  - ready_o=0 until the 4th HOLD completes.
